// File: rtl/shrimp_writeback.sv
// Writeback stage: buffers ALU results in a small in-order FIFO, commits them to an
// 8x8 register file and the architected Z/N/C/V flags, and forwards pending writes to operand reads.
package shrimp_alu_defs;
    typedef enum logic [2:0] {
        OP_ADDU = 3'd0,
        OP_ADDS = 3'd1,
        OP_NEG  = 3'd2,
        OP_XOR  = 3'd3,
        OP_AND  = 3'd4,
        OP_OR   = 3'd5,
        OP_CMP  = 3'd6,
        OP_NOP  = 3'd7
    } alu_opcode_e;
endpackage

module shrimp_writeback
    import shrimp_alu_defs::*;
#(
    parameter int FIFO_DEPTH = 2,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  alu_opcode_e      in_op,
    input  logic [7:0]       in_result,
    input  logic             in_carry,
    input  logic             in_overflow,
    input  logic [2:0]       in_rd,
    input  logic             in_we,
    input  logic             wb_stall,
    input  logic [2:0]       rs_a_addr,
    input  logic [2:0]       rs_b_addr,
    output logic [7:0]       rs_a_data,
    output logic [7:0]       rs_b_data,
    output logic             flag_z,
    output logic             flag_n,
    output logic             flag_c,
    output logic             flag_v,
    output logic [CNT_W-1:0] commit_count
);
    localparam int PTR_W = (FIFO_DEPTH > 2) ? 2 : 1;
    localparam int OCC_W = PTR_W + 1;

    alu_opcode_e      op_q    [FIFO_DEPTH];
    logic [7:0]       res_q   [FIFO_DEPTH];
    logic             carry_q [FIFO_DEPTH];
    logic             ovf_q   [FIFO_DEPTH];
    logic [2:0]       rd_q    [FIFO_DEPTH];
    logic             we_q    [FIFO_DEPTH];

    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [OCC_W-1:0] occ;
    logic [7:0]       regs [8];
    logic             push;
    logic             pop;
    logic [PTR_W-1:0] fwd_idx;

    // Returns {z, n, c, v} after committing an entry of the given op onto the current flags.
    function automatic logic [3:0] next_flags(input alu_opcode_e op, input logic [7:0] r,
                                              input logic cy, input logic ov,
                                              input logic [3:0] cur);
        logic z_r;
        logic n_r;
        z_r = (r == 8'h00);
        n_r = r[7];
        next_flags = cur;
        case (op)
            OP_XOR, OP_AND, OP_OR: next_flags = {z_r, n_r, 1'b0, 1'b0};
            OP_ADDU:               next_flags = {z_r, n_r, cy, cur[0]};
            OP_ADDS:               next_flags = {z_r, n_r, cur[1], ov};
            OP_NEG:                next_flags = {z_r, n_r, cur[1:0]};
            OP_CMP:                next_flags = {r[2], r[1], cur[1:0]};
            default:               next_flags = cur;
        endcase
    endfunction

    assign in_ready = !rst && (occ < OCC_W'(FIFO_DEPTH));
    assign push     = in_valid && in_ready;
    assign pop      = (occ != '0) && !wb_stall;

    // Walk pending entries oldest to youngest so the youngest matching write wins.
    always_comb begin
        rs_a_data = regs[rs_a_addr];
        rs_b_data = regs[rs_b_addr];
        fwd_idx   = rd_ptr;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            fwd_idx = rd_ptr + PTR_W'(i);
            if ((OCC_W'(i) < occ) && we_q[fwd_idx]) begin
                if (rd_q[fwd_idx] == rs_a_addr) rs_a_data = res_q[fwd_idx];
                if (rd_q[fwd_idx] == rs_b_addr) rs_b_data = res_q[fwd_idx];
            end
        end
        if (rs_a_addr == 3'd0) rs_a_data = 8'h00;
        if (rs_b_addr == 3'd0) rs_b_data = 8'h00;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            op_q[wr_ptr]    <= in_op;
            res_q[wr_ptr]   <= in_result;
            carry_q[wr_ptr] <= in_carry;
            ovf_q[wr_ptr]   <= in_overflow;
            rd_q[wr_ptr]    <= in_rd;
            we_q[wr_ptr]    <= in_we;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr       <= '0;
            wr_ptr       <= '0;
            occ          <= '0;
            flag_z       <= 1'b0;
            flag_n       <= 1'b0;
            flag_c       <= 1'b0;
            flag_v       <= 1'b0;
            commit_count <= '0;
            for (int r = 0; r < 8; r++) regs[r] <= 8'h00;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
                if (we_q[rd_ptr] && (rd_q[rd_ptr] != 3'd0)) regs[rd_q[rd_ptr]] <= res_q[rd_ptr];
                {flag_z, flag_n, flag_c, flag_v} <= next_flags(op_q[rd_ptr], res_q[rd_ptr],
                                                               carry_q[rd_ptr], ovf_q[rd_ptr],
                                                               {flag_z, flag_n, flag_c, flag_v});
                commit_count <= commit_count + 1'b1;
                rd_ptr       <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   occ <= occ + 1'b1;
                2'b01:   occ <= occ - 1'b1;
                default: occ <= occ;
            endcase
        end
    end
endmodule

// File: tb/tb_shrimp_writeback.sv
// Bench for shrimp_writeback: directed scenarios plus randomized traffic against a queue-based model.
module tb_shrimp_writeback;
    import shrimp_alu_defs::*;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst, in_valid, in_carry, in_overflow, in_we, wb_stall;
    alu_opcode_e in_op;
    logic [7:0]  in_result;
    logic [2:0]  in_rd, rs_a_addr, rs_b_addr;

    logic        in_ready, flag_z, flag_n, flag_c, flag_v;
    logic [7:0]  rs_a_data, rs_b_data;
    logic [15:0] commit_count;
    logic        in_ready_w, flag_z_w, flag_n_w, flag_c_w, flag_v_w;
    logic [7:0]  rs_a_data_w, rs_b_data_w;
    logic [3:0]  commit_count_w;

    int checks = 0;
    int failures = 0;

    shrimp_writeback #(.FIFO_DEPTH(DEPTH), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_result(in_result), .in_carry(in_carry), .in_overflow(in_overflow), .in_rd(in_rd),
        .in_we(in_we), .wb_stall(wb_stall), .rs_a_addr(rs_a_addr), .rs_b_addr(rs_b_addr),
        .rs_a_data(rs_a_data), .rs_b_data(rs_b_data), .flag_z(flag_z), .flag_n(flag_n),
        .flag_c(flag_c), .flag_v(flag_v), .commit_count(commit_count)
    );

    // Narrow-counter copy sharing the same stimulus, so counter wrap is reached quickly.
    shrimp_writeback #(.FIFO_DEPTH(DEPTH), .CNT_W(4)) dut_w (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_w), .in_op(in_op),
        .in_result(in_result), .in_carry(in_carry), .in_overflow(in_overflow), .in_rd(in_rd),
        .in_we(in_we), .wb_stall(wb_stall), .rs_a_addr(rs_a_addr), .rs_b_addr(rs_b_addr),
        .rs_a_data(rs_a_data_w), .rs_b_data(rs_b_data_w), .flag_z(flag_z_w), .flag_n(flag_n_w),
        .flag_c(flag_c_w), .flag_v(flag_v_w), .commit_count(commit_count_w)
    );

    initial forever #5 clk = ~clk;

    typedef struct packed {
        alu_opcode_e op;
        logic [7:0]  res;
        logic        c;
        logic        v;
        logic [2:0]  rd;
        logic        we;
    } ent_t;

    ent_t        q[$];
    logic [7:0]  mreg [8];
    logic        mz, mn, mc, mv;
    int unsigned mcount;

    function automatic logic [7:0] mfwd(input logic [2:0] a);
        if (a == 3'd0) return 8'h00;
        for (int i = q.size() - 1; i >= 0; i--)
            if (q[i].we && q[i].rd == a) return q[i].res;
        return mreg[a];
    endfunction

    function automatic logic mready();
        return !rst && (q.size() < DEPTH);
    endfunction

    function automatic logic [33:0] exp_comb();
        logic [16:0] e;
        e = {mready(), mfwd(rs_a_addr), mfwd(rs_b_addr)};
        return {e, e};
    endfunction

    function automatic logic [27:0] exp_state();
        logic [31:0] cnt;
        cnt = mcount;
        return {mz, mn, mc, mv, mz, mn, mc, mv, cnt[15:0], cnt[3:0]};
    endfunction

    wire [33:0] obs_comb  = {in_ready, rs_a_data, rs_b_data, in_ready_w, rs_a_data_w, rs_b_data_w};
    wire [27:0] obs_state = {flag_z, flag_n, flag_c, flag_v, flag_z_w, flag_n_w, flag_c_w, flag_v_w,
                             commit_count, commit_count_w};
    wire [3:0]  flags     = {flag_z, flag_n, flag_c, flag_v};

    task automatic model_edge();
        ent_t e;
        bit   do_push, do_pop;
        if (rst) begin
            q.delete();
            for (int r = 0; r < 8; r++) mreg[r] = 8'h00;
            {mz, mn, mc, mv} = 4'b0000;
            mcount = 0;
            return;
        end
        do_push = in_valid && (q.size() < DEPTH);
        do_pop  = (q.size() > 0) && !wb_stall;
        if (do_pop) begin
            e = q.pop_front();
            if (e.we && e.rd != 3'd0) mreg[e.rd] = e.res;
            mcount++;
            case (e.op)
                OP_XOR, OP_AND, OP_OR: begin mz = (e.res == 0); mn = e.res[7]; mc = 0; mv = 0; end
                OP_ADDU: begin mz = (e.res == 0); mn = e.res[7]; mc = e.c; end
                OP_ADDS: begin mz = (e.res == 0); mn = e.res[7]; mv = e.v; end
                OP_NEG:  begin mz = (e.res == 0); mn = e.res[7]; end
                OP_CMP:  begin mz = e.res[2]; mn = e.res[1]; end
                default: ;
            endcase
        end
        if (do_push) begin
            e.op = in_op; e.res = in_result; e.c = in_carry; e.v = in_overflow;
            e.rd = in_rd; e.we = in_we;
            q.push_back(e);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic drive(input logic v, input alu_opcode_e op, input logic [7:0] r,
                         input logic c, input logic o, input logic [2:0] rd, input logic we);
        in_valid = v; in_op = op; in_result = r; in_carry = c; in_overflow = o;
        in_rd = rd; in_we = we;
    endtask

    task automatic do_reset();
        rst = 1'b1; in_valid = 1'b0; wb_stall = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; wb_stall = 1'b0;
        drive(1'b1, OP_ADDU, 8'h55, 1'b1, 1'b1, 3'd1, 1'b1);
        #1;
        checks++;
        if (in_ready !== 1'b0 || in_ready_w !== 1'b0) begin
            failures++; $display("FAIL reset_ready_low got=%b/%b exp=0", in_ready, in_ready_w);
        end
        tick(); tick();
        checks++;
        if ({flags, commit_count} !== 20'h0 || obs_state !== exp_state()) begin
            failures++; $display("FAIL reset_state got=%h exp=%h", obs_state, exp_state());
        end
        for (int a = 0; a < 8; a++) begin
            rs_a_addr = 3'(a); #1;
            checks++;
            if (rs_a_data !== 8'h00) begin
                failures++; $display("FAIL reset_reg%0d got=%h exp=00", a, rs_a_data);
            end
        end
        rst = 1'b0; in_valid = 1'b0; #1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++; $display("FAIL reset_ready_high got=%b exp=1", in_ready);
        end
    endtask

    task automatic test_addu_commit();
        do_reset();
        drive(1'b1, OP_ADDU, 8'h00, 1'b1, 1'b0, 3'd3, 1'b1);
        rs_a_addr = 3'd3; rs_b_addr = 3'd0;
        tick();
        in_valid = 1'b0; #1;
        checks++;
        if (commit_count !== 16'd0 || flags !== 4'b0000) begin
            failures++; $display("FAIL addu_latency got=cnt %0d flags %b exp=cnt 0 flags 0000", commit_count, flags);
        end
        tick();
        checks++;
        if (flags !== 4'b1010 || commit_count !== 16'd1 || rs_a_data !== 8'h00) begin
            failures++; $display("FAIL addu_commit got=flags %b cnt %0d r3 %h exp=1010 1 00", flags, commit_count, rs_a_data);
        end
    endtask

    task automatic test_stall_backpressure();
        ent_t e [3];
        e[0] = '{OP_OR,   8'h0F, 1'b0, 1'b0, 3'd1, 1'b1};
        e[1] = '{OP_XOR,  8'hF0, 1'b0, 1'b0, 3'd2, 1'b1};
        e[2] = '{OP_ADDU, 8'h33, 1'b1, 1'b0, 3'd4, 1'b1};
        do_reset();
        wb_stall = 1'b1; rs_a_addr = 3'd1; rs_b_addr = 3'd4;
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, e[k].op, e[k].res, e[k].c, e[k].v, e[k].rd, e[k].we); #1;
            checks++;
            if (in_ready !== (k < 2)) begin
                failures++; $display("FAIL stall_ready%0d got=%b exp=%b", k, in_ready, (k < 2));
            end
            tick();
        end
        wb_stall = 1'b0; #1;
        checks++;
        if (in_ready !== 1'b0) begin
            failures++; $display("FAIL full_ready_no_pop_dep got=%b exp=0", in_ready);
        end
        tick();
        checks++;
        if (commit_count !== 16'd1 || rs_a_data !== 8'h0F || in_ready !== 1'b1) begin
            failures++; $display("FAIL first_commit got=cnt %0d r1 %h rdy %b exp=1 0f 1", commit_count, rs_a_data, in_ready);
        end
        tick();
        in_valid = 1'b0;
        tick();
        rs_a_addr = 3'd2; #1;
        checks++;
        if (commit_count !== 16'd3 || rs_a_data !== 8'hF0 || rs_b_data !== 8'h33 || flags !== 4'b0010) begin
            failures++; $display("FAIL drain_order got=cnt %0d r2 %h r4 %h flags %b exp=3 f0 33 0010",
                                 commit_count, rs_a_data, rs_b_data, flags);
        end
    endtask

    task automatic test_forward_adds();
        do_reset();
        drive(1'b1, OP_ADDU, 8'h01, 1'b1, 1'b0, 3'd6, 1'b1);
        tick();
        in_valid = 1'b0;
        tick();
        wb_stall = 1'b1; rs_a_addr = 3'd2; rs_b_addr = 3'd6;
        drive(1'b1, OP_ADDS, 8'h80, 1'b0, 1'b1, 3'd2, 1'b1);
        #1;
        checks++;
        if (rs_a_data !== 8'h00) begin
            failures++; $display("FAIL no_forward_unaccepted got=%h exp=00", rs_a_data);
        end
        tick();
        in_valid = 1'b0;
        tick();
        checks++;
        if (rs_a_data !== 8'h80 || commit_count !== 16'd1) begin
            failures++; $display("FAIL adds_forward got=%h cnt %0d exp=80 1", rs_a_data, commit_count);
        end
        wb_stall = 1'b0;
        tick();
        checks++;
        if (flags !== 4'b0111 || rs_a_data !== 8'h80 || commit_count !== 16'd2) begin
            failures++; $display("FAIL adds_commit got=flags %b r2 %h cnt %0d exp=0111 80 2", flags, rs_a_data, commit_count);
        end
    endtask

    task automatic test_forward_youngest();
        do_reset();
        wb_stall = 1'b1; rs_a_addr = 3'd0; rs_b_addr = 3'd5;
        drive(1'b1, OP_NOP, 8'h11, 1'b1, 1'b1, 3'd5, 1'b1);
        tick();
        drive(1'b1, OP_NOP, 8'h22, 1'b1, 1'b1, 3'd5, 1'b1);
        tick();
        drive(1'b1, OP_OR, 8'h5A, 1'b0, 1'b0, 3'd0, 1'b1); #1;
        checks++;
        if (rs_b_data !== 8'h22) begin
            failures++; $display("FAIL forward_youngest got=%h exp=22", rs_b_data);
        end
        wb_stall = 1'b0;
        tick(); tick();
        in_valid = 1'b0; #1;
        checks++;
        if (flags !== 4'b0000 || rs_a_data !== 8'h00 || rs_b_data !== 8'h22 || commit_count !== 16'd2) begin
            failures++; $display("FAIL other_op_and_r0 got=flags %b r0 %h r5 %h cnt %0d exp=0000 00 22 2",
                                 flags, rs_a_data, rs_b_data, commit_count);
        end
        tick();
        checks++;
        if (rs_a_data !== 8'h00 || rs_b_data !== 8'h22 || commit_count !== 16'd3) begin
            failures++; $display("FAIL r0_write_ignored got=r0 %h r5 %h cnt %0d exp=00 22 3", rs_a_data, rs_b_data, commit_count);
        end
    endtask

    task automatic test_cmp_and();
        do_reset();
        rs_a_addr = 3'd1; rs_b_addr = 3'd7;
        drive(1'b1, OP_ADDU, 8'h7F, 1'b1, 1'b0, 3'd1, 1'b1);
        tick();
        drive(1'b1, OP_CMP, 8'h04, 1'b0, 1'b1, 3'd7, 1'b0);
        tick();
        drive(1'b1, OP_AND, 8'h80, 1'b1, 1'b1, 3'd7, 1'b0);
        tick();
        in_valid = 1'b0; #1;
        checks++;
        if (flags !== 4'b1010) begin
            failures++; $display("FAIL cmp_flags got=%b exp=1010", flags);
        end
        tick();
        checks++;
        if (flags !== 4'b0100 || rs_a_data !== 8'h7F || rs_b_data !== 8'h00 || commit_count !== 16'd3) begin
            failures++; $display("FAIL and_flags got=flags %b r1 %h r7 %h cnt %0d exp=0100 7f 00 3",
                                 flags, rs_a_data, rs_b_data, commit_count);
        end
    endtask

    task automatic test_reset_priority();
        do_reset();
        rs_a_addr = 3'd1; rs_b_addr = 3'd2;
        drive(1'b1, OP_ADDU, 8'h90, 1'b1, 1'b0, 3'd3, 1'b1);
        tick();
        wb_stall = 1'b1;
        drive(1'b1, OP_ADDU, 8'h81, 1'b1, 1'b1, 3'd1, 1'b1);
        tick();
        drive(1'b1, OP_ADDS, 8'h82, 1'b1, 1'b1, 3'd2, 1'b1);
        tick();
        rst = 1'b1; wb_stall = 1'b0;
        drive(1'b1, OP_OR, 8'h83, 1'b0, 1'b0, 3'd3, 1'b1); #1;
        checks++;
        if (in_ready !== 1'b0) begin
            failures++; $display("FAIL rst_ready got=%b exp=0", in_ready);
        end
        tick();
        rst = 1'b0; in_valid = 1'b0; #1;
        checks++;
        if (flags !== 4'b0000 || commit_count !== 16'd0 || rs_a_data !== 8'h00 || rs_b_data !== 8'h00) begin
            failures++; $display("FAIL rst_priority got=flags %b cnt %0d r1 %h r2 %h exp=0000 0 00 00",
                                 flags, commit_count, rs_a_data, rs_b_data);
        end
        rs_a_addr = 3'd3;
        tick(); tick();
        checks++;
        if (commit_count !== 16'd0 || rs_a_data !== 8'h00) begin
            failures++; $display("FAIL rst_discard got=cnt %0d r3 %h exp=0 00", commit_count, rs_a_data);
        end
    endtask

    task automatic test_count_wrap();
        do_reset();
        for (int k = 0; k < 16; k++) begin
            drive(1'b1, alu_opcode_e'(3'($urandom_range(0, 7))), 8'($urandom), 1'($urandom),
                  1'($urandom), 3'($urandom), 1'($urandom));
            tick();
        end
        in_valid = 1'b0; #1;
        checks++;
        if (commit_count_w !== 4'hF || commit_count !== 16'd15) begin
            failures++; $display("FAIL count_max got=%h/%0d exp=f/15", commit_count_w, commit_count);
        end
        tick();
        checks++;
        if (commit_count_w !== 4'h0 || commit_count !== 16'd16) begin
            failures++; $display("FAIL count_wrap got=%h/%0d exp=0/16", commit_count_w, commit_count);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 600; n++) begin
            rst      = ($urandom_range(0, 49) == 0);
            wb_stall = ($urandom_range(0, 2) == 0);
            drive(($urandom_range(0, 2) != 0), alu_opcode_e'(3'($urandom_range(0, 7))), 8'($urandom),
                  1'($urandom), 1'($urandom), 3'($urandom), 1'($urandom));
            if ($urandom_range(0, 3) == 0) in_result = 8'h00;
            rs_a_addr = 3'($urandom); rs_b_addr = 3'($urandom);
            #1;
            checks++;
            if (obs_comb !== exp_comb()) begin
                failures++; $display("FAIL rand_comb cyc %0d got=%h exp=%h", n, obs_comb, exp_comb());
            end
            tick();
            checks++;
            if (obs_state !== exp_state()) begin
                failures++; $display("FAIL rand_state cyc %0d got=%h exp=%h", n, obs_state, exp_state());
            end
        end
        rst = 1'b0; in_valid = 1'b0; wb_stall = 1'b0;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; wb_stall = 1'b0;
        drive(1'b0, OP_NOP, 8'h00, 1'b0, 1'b0, 3'd0, 1'b0);
        rs_a_addr = 3'd0; rs_b_addr = 3'd0;
        test_reset();
        test_addu_commit();
        test_stall_backpressure();
        test_forward_adds();
        test_forward_youngest();
        test_cmp_and();
        test_reset_priority();
        test_count_wrap();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/shrimp_writeback.md
SHRIMP_WRITEBACK -- requirements
Module: shrimp_writeback

Interface
REQ-001 Parameter FIFO_DEPTH, default 2, number of pending ALU results buffered; legal values are 2 or 4.
REQ-002 Parameter CNT_W, default 16, width of the commit counter.
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 in_valid  input  1  ALU result presented this cycle.
REQ-006 in_ready  output  1  block accepts a result this cycle.
REQ-007 in_op  input  alu_opcode_e  op_code that produced the result (shared shrimp_alu_defs enum).
REQ-008 in_result  input  8  ALU result.
REQ-009 in_carry, in_overflow  input  1 each  ALU carry and overflow.
REQ-010 in_rd  input  3  destination register index.
REQ-011 in_we  input  1  write in_result to in_rd on commit.
REQ-012 wb_stall  input  1  blocks commit this cycle.
REQ-013 rs_a_addr, rs_b_addr  input  3 each  operand read addresses.
REQ-014 rs_a_data, rs_b_data  output  8 each  operand read data, combinational, feeding ALU operand_a/operand_b.
REQ-015 flag_z, flag_n, flag_c, flag_v  output  1 each  architected flags.
REQ-016 commit_count  output  CNT_W  number of committed entries.

Function
REQ-017 Accept: an entry {op,result,carry,overflow,rd,we} SHALL be pushed when in_valid && in_ready.
REQ-018 in_ready SHALL be 1 iff FIFO occupancy < FIFO_DEPTH (no dependence on in_valid or same-cycle pop).
REQ-019 Commit: the oldest entry SHALL pop when occupancy > 0 && !wb_stall; at most one commit per cycle.
REQ-020 Push and pop in the same cycle SHALL leave occupancy unchanged; entries commit strictly in arrival order.
REQ-021 Accept-to-visible latency SHALL be one cycle minimum: an entry accepted at edge N commits at edge N+1 at the earliest.
REQ-022 Register file: 8 x 8-bit; R0 SHALL read 0 and ignore writes; commit with we=1 and rd!=0 writes result to rd.
REQ-023 Read forwarding: rs_x_data SHALL return the youngest pending FIFO entry with we=1 and matching rd, else the register file; address 0 always returns 0.
REQ-024 Incoming (not yet accepted) in_* values SHALL NOT be forwarded.
REQ-025 Flag update on commit by op: XOR/AND/OR -> Z,N from result, C=0, V=0.
REQ-026 ADDU -> Z,N from result, C=carry, V unchanged.
REQ-027 ADDS -> Z,N from result, V=overflow, C unchanged.
REQ-028 NEG -> Z,N from result, C,V unchanged.
REQ-029 CMP -> Z=result[2], N=result[1], C,V unchanged.
REQ-030 Any other encoding -> all flags unchanged; register write still honours we.
REQ-031 Z = (result==0), N = result[7] where "from result" applies.
REQ-032 Flags SHALL update regardless of we.
REQ-033 commit_count SHALL increment by 1 per commit and wrap from 2^CNT_W-1 to 0.
REQ-034 Occupancy counter and FIFO pointers SHALL wrap modulo FIFO_DEPTH without loss or duplication.

Reset
REQ-035 While rst=1 at a clock edge: FIFO emptied, all 8 registers = 0, all flags = 0, commit_count = 0; in_ready = 1 from the first cycle after that edge.
REQ-036 Reset SHALL take priority over push and commit in the same cycle; pending entries are discarded, not committed.
REQ-037 in_ready SHALL be 0 during cycles in which rst=1.

Verification
REQ-038 Reset, push ADDU result=0x00 carry=1 rd=3 we=1, wb_stall=0 -> next edge R3=0x00, Z=1, N=0, C=1, V=0, commit_count=1.
REQ-039 wb_stall=1, push 3 entries back-to-back (FIFO_DEPTH=2) -> in_ready drops to 0 after 2 accepts; the third is held until stall releases; all three commit in order.
REQ-040 Pending ADDS to R2=0x80 (stalled), rs_a_addr=2 -> rs_a_data=0x80 before commit; after commit V=overflow, N=1, C unchanged.
REQ-041 Two pending writes to R5 (0x11 then 0x22), rs_b_addr=5 -> rs_b_data=0x22; write to R0 -> R0 still reads 0.
REQ-042 CMP result=0x04 after ADDU with carry=1 -> Z=1, N=0, C=1 retained; then AND result=0x80 -> N=1, Z=0, C=0, V=0.
REQ-043 rst asserted with 2 entries pending and push active -> no commit, all outputs at reset values; commit_count=0xFFFF plus one commit -> 0x0000.
